mem_reduce_unit: RTL

- Parametrised register-file memory with a built-in reduction engine, the next generation of the lab5 memory/summation block.
- Host writes and reads words through a simple we/re port.
- A start pulse reduces an inclusive, wrap-around address range [first..last] with one of four operations (SUM/MAX/MIN/XOR) and returns the result on ans with a one-cycle done pulse.

---
 rtl/mem_reduce_unit_if.sv | 29 ++
 rtl/mem_reduce_unit.sv | 110 +++++++++++
 2 files changed

// File: rtl/mem_reduce_unit_if.sv
// rtl/mem_reduce_unit_if.sv - host bus of mem_reduce_unit: word read/write port plus reduction control/result.
interface mem_reduce_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int ACC_W  = 8
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] din;
  logic              re;
  logic [DATA_W-1:0] dout;
  logic              start;
  logic [ADDR_W-1:0] first;
  logic [ADDR_W-1:0] last;
  logic [1:0]        mode;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  ans;

  modport master (
    output addr, we, din, re, start, first, last, mode,
    input  dout, busy, done, ans
  );

  modport slave (
    input  addr, we, din, re, start, first, last, mode,
    output dout, busy, done, ans
  );
endinterface

// File: rtl/mem_reduce_unit.sv
// rtl/mem_reduce_unit.sv - register-file memory with SUM/MAX/MIN/XOR range reduction over a wrap-around range.
// Optional macro REDUCE_SAT_EN: SUM saturates at all-ones instead of wrapping.
module mem_reduce_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int ACC_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_reduce_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q;
  logic [ACC_W-1:0]  acc_q, ans_q;
  logic [ADDR_W-1:0] ptr_q, rem_q;
  logic [1:0]        mode_q;
  logic              done_q;

  logic              busy, load_en, step_en, last_step;
  logic [ACC_W-1:0]  elem, acc_init, acc_nxt;
`ifdef REDUCE_SAT_EN
  logic [ACC_W:0]    sum_ext;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // rem_q holds elements left after the current one, so zero marks the final step
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (rem_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN);
    load_en   = (state_q == IDLE) && bus.start;
    step_en   = (state_q == RUN);
    last_step = (state_q == RUN) && (rem_q == '0);
  end

  assign elem     = ACC_W'(mem_q[ptr_q]);
  assign acc_init = (bus.mode == 2'd2) ? '1 : '0;

  always_comb begin
    acc_nxt = acc_q;
`ifdef REDUCE_SAT_EN
    sum_ext = {1'b0, acc_q} + {1'b0, elem};
`endif
    case (mode_q)
      2'd0: begin
`ifdef REDUCE_SAT_EN
        acc_nxt = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
        acc_nxt = acc_q + elem;
`endif
      end
      2'd1:    acc_nxt = (elem > acc_q) ? elem : acc_q;
      2'd2:    acc_nxt = (elem < acc_q) ? elem : acc_q;
      default: acc_nxt = acc_q ^ elem;
    endcase
  end

  // Nonblocking read and write on the same edge give read-before-write for free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      dout_q <= '0;
      acc_q  <= '0;
      ans_q  <= '0;
      ptr_q  <= '0;
      rem_q  <= '0;
      mode_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.we && !busy) mem_q[bus.addr] <= bus.din;
      if (bus.re) dout_q <= mem_q[bus.addr];
      if (load_en) begin
        ptr_q  <= bus.first;
        rem_q  <= bus.last - bus.first;
        mode_q <= bus.mode;
        acc_q  <= acc_init;
      end else if (step_en) begin
        acc_q <= acc_nxt;
        ptr_q <= ptr_q + 1'b1;
        rem_q <= rem_q - 1'b1;
        if (last_step) begin
          ans_q  <= acc_nxt;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.dout = dout_q;
  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.ans  = ans_q;
endmodule
